bennett_clock_monitor: RTL
==========================

# bennett_clock_monitor

Receiving-end checker for the Bennett ramp-clock rails. Samples the complementary `clkp`/`clkn` staircase on the system clock, decodes the thermometer level, tracks rise/fall phase, and pulses at peak and at frame completion. It raises sticky error flags when the rails violate the protocol. It sits beside adiabatic logic stages and is used both as an in-system health monitor and as a bench-side protocol checker.

## Interface

- `WIDTH`, 11: number of rail pairs; legal range 2..15.
- `LW`, $clog2(WIDTH+1): width of the `level` output.
- `clk`  in  1  system clock; the rails are generated synchronously to it.
- `reset`  in  1  asynchronous, active-high.
- `clkp`  in  WIDTH  positive rails; thermometer code with bit 0 rising first.
- `clkn`  in  WIDTH  negative rails; must equal ~`clkp`.
- `err_clr`  in  1  synchronous clear of all sticky error flags.
- `level`  out  LW  decoded level, 0..WIDTH.
- `rising`  out  1  1 while locked in the rising half, 0 otherwise.
- `peak`  out  1  one-cycle pulse when level WIDTH is accepted while locked.
- `frame_done`  out  1  one-cycle pulse when locked and the level returns to 0.
- `locked`  out  1  protocol lock.
- `err_rail`  out  1  sticky; some bit had `clkp[i]==clkn[i]`.
- `err_therm`  out  1  sticky; `clkp` was not of the form 2^k-1.
- `err_step`  out  1  sticky; a locked sample had a valid code but an unexpected level.
- `frame_count`  out  16  completed frames (see Configuration).
- `err_count`  out  8  error events, saturating (see Configuration).

## Operation

- Protocol: level steps once per clk: 0,1,…,WIDTH,WIDTH-1,…,1,0,… The period is 2·WIDTH cycles.
- Stage 1 registers `clkp`/`clkn` into `p_q`/`n_q`. Stage 2 decodes and compares, then updates all outputs.
- Decode: the sample is valid when `n_q==~p_q` and `p_q` is a thermometer code. The level is the number of ones. For an invalid sample, `level` holds its previous value.
- FSM states are UNLOCKED, RISE and FALL.
- UNLOCKED: on a valid level-0 sample, go to RISE and set `locked`. This sample does not pulse `frame_done`. Every other sample stays in UNLOCKED.
- RISE: the expected level is prev+1.
  - On an accepted level WIDTH, pulse `peak` and go to FALL.
- FALL: the expected level is prev-1.
  - On an accepted level 0, pulse `frame_done` and go to RISE.
- Any invalid sample while locked does three things:
  - sets the matching `err_rail` and/or `err_therm`;
  - clears `locked`;
  - moves the FSM to UNLOCKED.
- A valid but unexpected level while locked sets `err_step`, clears `locked` and moves the FSM to UNLOCKED.
- `err_rail` and `err_therm` are also set when a violation occurs while unlocked. `err_step` is only set while locked.
- `rising` is 1 only in RISE.
- `err_clr`: clears all three flags. If a new error occurs in the same cycle, the new error wins and its flag reads 1.

## Timing

- Reset values (asynchronous): `p_q`=0, `n_q`=all ones, FSM=UNLOCKED. All outputs are 0, including both counters.
- Latency: rails applied before edge N are captured at N. Outputs reflecting them update at edge N+1, a fixed 2-edge latency.
- `peak` and `frame_done` are high for exactly one cycle and are never high together.
- Reset asserted mid-frame forces UNLOCKED at once. Relock occurs on the first valid level-0 sample after release, so `locked` rises within 2·WIDTH+2 cycles.
- The level-0 sample that causes relock after an error counts as a lock sample and does not pulse `frame_done`.

## Configuration

- `BCLK_MON_STATS_EN` defined:
  - `frame_count` increments on each `frame_done` and wraps at 2^16.
  - `err_count` increments by 1 per cycle in which any error condition is detected, and saturates at 255.
  - `err_clr` also zeroes `err_count`. It does not zero `frame_count`.
- Not defined: both counter outputs are tied to 0 and their registers are not synthesized.

## Test plan

- WIDTH=11, clean staircase from reset for 3 periods -> `locked`=1 two edges after the first level-0 sample. `peak` pulses every 22 cycles. `frame_done` pulses 11 cycles after each `peak`. No error flags. `frame_count`=3 with the macro enabled.
- Flip `clkn[4]` so it equals `clkp[4]` for one cycle at level 6 -> `err_rail`=1 and `locked`=0. Relock occurs at the next level 0. `err_count`=1.
- Drive `clkp`=11'b00000000101 while locked -> `err_therm`=1, `level` holds its prior value, `locked`=0.
- Skip from level 5 to level 7 while rising -> `err_step`=1 and `locked`=0. Then pulse `err_clr` in the same cycle as a repeat skip after relock -> `err_step` stays 1.
- Assert `reset` at level 8 while falling -> all outputs 0 immediately. After release, no `frame_done` is seen until a full 0→11→0 traversal completes.
- WIDTH=2 minimal staircase 0,1,2,1,0 -> `peak`/`frame_done` period of 4 cycles, `level` width 2 bits.

Source files
------------

// File: rtl/bennett_clock_monitor.sv
// Bennett ramp-clock rail checker: two-stage sample/decode, lock FSM, sticky protocol errors.
// Define BCLK_MON_STATS_EN to build the frame_count / err_count statistics counters.
module bennett_clock_monitor #(
    parameter int WIDTH = 11,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] clkp,
    input  logic [WIDTH-1:0] clkn,
    input  logic             err_clr,
    output logic [LW-1:0]    level,
    output logic             rising,
    output logic             peak,
    output logic             frame_done,
    output logic             locked,
    output logic             err_rail,
    output logic             err_therm,
    output logic             err_step,
    output logic [15:0]      frame_count,
    output logic [7:0]       err_count
);
    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);
    localparam logic [LW-1:0]    L_ONE = LW'(1);
    localparam logic [LW-1:0]    L_MAX = LW'(WIDTH);

    typedef enum logic [1:0] {UNLOCKED, RISE, FALL} state_t;
    state_t state;

    logic [WIDTH-1:0] p_q, n_q;
    logic             s1_vld;
    logic             rail_ok, therm_ok, smp_ok;
    logic [LW-1:0]    ones, exp_lvl;
    logic             hit, new_rail, new_therm, new_step, top_evt, bot_evt;

    // s1_vld keeps the reset image of p_q/n_q (a legal level 0) from being taken as a lock sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q    <= '0;
            n_q    <= '1;
            s1_vld <= 1'b0;
        end else begin
            p_q    <= clkp;
            n_q    <= clkn;
            s1_vld <= 1'b1;
        end
    end

    always_comb begin
        rail_ok  = (n_q == ~p_q);
        therm_ok = ((p_q & (p_q + W_ONE)) == '0);
        ones     = '0;
        for (int i = 0; i < WIDTH; i++)
            ones = ones + {{(LW-1){1'b0}}, p_q[i]};
        exp_lvl  = (state == FALL) ? level - L_ONE : level + L_ONE;
    end

    assign smp_ok    = rail_ok && therm_ok;
    assign new_rail  = s1_vld && !rail_ok;
    assign new_therm = s1_vld && !therm_ok;
    assign hit       = s1_vld && smp_ok && (ones == exp_lvl);
    assign new_step  = s1_vld && smp_ok && (state != UNLOCKED) && (ones != exp_lvl);
    assign top_evt   = (state == RISE) && hit && (ones == L_MAX);
    assign bot_evt   = (state == FALL) && hit && (ones == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= UNLOCKED;
            level      <= '0;
            rising     <= 1'b0;
            peak       <= 1'b0;
            frame_done <= 1'b0;
            locked     <= 1'b0;
            err_rail   <= 1'b0;
            err_therm  <= 1'b0;
            err_step   <= 1'b0;
        end else begin
            peak       <= 1'b0;
            frame_done <= 1'b0;
            // A fresh error in the clear cycle still leaves its flag set.
            err_rail   <= (err_rail  && !err_clr) || new_rail;
            err_therm  <= (err_therm && !err_clr) || new_therm;
            err_step   <= (err_step  && !err_clr) || new_step;
            if (s1_vld && smp_ok)
                level <= ones;
            if (s1_vld) begin
                case (state)
                    UNLOCKED: begin
                        if (smp_ok && ones == '0) begin
                            state  <= RISE;
                            locked <= 1'b1;
                            rising <= 1'b1;
                        end
                    end
                    RISE: begin
                        if (top_evt) begin
                            state  <= FALL;
                            rising <= 1'b0;
                            peak   <= 1'b1;
                        end else if (!hit) begin
                            state  <= UNLOCKED;
                            locked <= 1'b0;
                            rising <= 1'b0;
                        end
                    end
                    FALL: begin
                        if (bot_evt) begin
                            state      <= RISE;
                            rising     <= 1'b1;
                            frame_done <= 1'b1;
                        end else if (!hit) begin
                            state  <= UNLOCKED;
                            locked <= 1'b0;
                            rising <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= UNLOCKED;
                        locked <= 1'b0;
                        rising <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef BCLK_MON_STATS_EN
    logic any_err;
    assign any_err = new_rail || new_therm || new_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (bot_evt)
                frame_count <= frame_count + 16'd1;
            if (err_clr)
                err_count <= {7'd0, any_err};
            else if (any_err && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end
`else
    assign frame_count = '0;
    assign err_count   = '0;
`endif

endmodule
